// File: rtl/mux_n1_stream.sv
// mux_n1_stream: N:1 stream multiplexer with a registered, handshaked output.
// Each input channel is a valid/ready stream. The winning channel is chosen
// either by a fixed index (mode_in=0) or by round-robin arbitration among the
// valid channels (mode_in=1). The winner's data is captured into a one-entry
// output register, which can refill in the same cycle it drains.
module mux_n1_stream #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      mode_in,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [CHANNELS-1:0]       valid_in,
    output logic [CHANNELS-1:0]       ready_out,
    output logic [WIDTH-1:0]          y_out,
    output logic [SEL_W-1:0]          y_chan,
    output logic                      y_valid,
    input  logic                      y_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_out_q, y_out_d;
    logic [SEL_W-1:0] y_chan_q, y_chan_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             load_en;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_data;

    // The output register may load whenever it is empty or being drained.
    assign load_en = (state_q == EMPTY) || y_ready;
    assign in_xfer = load_en && grant_valid;

    // Grant selection: fixed index, or first valid channel after last_grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant       = '0;
        grant_valid = 1'b0;
        if (!mode_in) begin
            // Comparing against each legal index means an out-of-range
            // sel_in simply matches nothing and never grants.
            for (int k = 0; k < CHANNELS; k++) begin
                if (sel_in == SEL_W'(k) && valid_in[k]) begin
                    grant       = SEL_W'(k);
                    grant_valid = 1'b1;
                end
            end
        end else begin
            // Step i visits channel (last_grant + 1 + i) mod CHANNELS;
            // the first valid one visited wins.
            for (int i = 0; i < CHANNELS; i++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (!grant_valid && valid_in[k] &&
                        k == (int'(last_grant_q) + 1 + i) % CHANNELS) begin
                        grant       = SEL_W'(k);
                        grant_valid = 1'b1;
                    end
                end
            end
        end
    end

    // One-hot ready to the granted channel; forced low while reset is held.
    always_comb begin
        ready_out = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (resetn && in_xfer && grant == SEL_W'(k)) begin
                ready_out[k] = 1'b1;
            end
        end
    end

    // Data mux: pick the granted channel's slice of the flattened input.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant == SEL_W'(k)) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic for the output stage and the round-robin pointer.
    always_comb begin
        state_d      = state_q;
        y_out_d      = y_out_q;
        y_chan_d     = y_chan_q;
        last_grant_d = last_grant_q;
        if (in_xfer) begin
            // A new beat replaces the held one even if it drains this cycle.
            state_d  = FULL;
            y_out_d  = sel_data;
            y_chan_d = grant;
            if (mode_in) begin
                last_grant_d = grant;
            end
        end else if (state_q == FULL && y_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers; reset clears the held beat without waiting for a clock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state_q      <= EMPTY;
            y_out_q      <= '0;
            y_chan_q     <= '0;
            last_grant_q <= SEL_W'(CHANNELS - 1);
        end else begin
            state_q      <= state_d;
            y_out_q      <= y_out_d;
            y_chan_q     <= y_chan_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign y_out   = y_out_q;
    assign y_chan  = y_chan_q;
    assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_n1_stream.sv
// Testbench for mux_n1_stream: a vector table, hand-written corner sequences,
// and a randomized phase checked against a queue-based reference model.
module tb_mux_n1_stream;

    localparam int W   = 8;
    localparam int CH  = 4;
    localparam int CH3 = 3;

    logic            clock;
    logic            resetn;

    // 4-channel instance
    logic            mode_in;
    logic [1:0]      sel_in;
    logic [CH*W-1:0] data_in;
    logic [CH-1:0]   valid_in;
    logic [CH-1:0]   ready_out;
    logic [W-1:0]    y_out;
    logic [1:0]      y_chan;
    logic            y_valid;
    logic            y_ready;

    // 3-channel instance (select still 2 bits wide, so index 3 is illegal)
    logic             m3_mode;
    logic [1:0]       m3_sel;
    logic [CH3*W-1:0] m3_data;
    logic [CH3-1:0]   m3_valid;
    logic [CH3-1:0]   m3_ready_out;
    logic [W-1:0]     m3_y_out;
    logic [1:0]       m3_y_chan;
    logic             m3_y_valid;
    logic             m3_y_ready;

    int checks = 0;
    int errors = 0;

    mux_n1_stream #(.WIDTH(W), .CHANNELS(CH), .SEL_W(2)) dut (
        .clock(clock), .resetn(resetn), .mode_in(mode_in), .sel_in(sel_in),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .y_out(y_out), .y_chan(y_chan), .y_valid(y_valid), .y_ready(y_ready)
    );

    mux_n1_stream #(.WIDTH(W), .CHANNELS(CH3), .SEL_W(2)) dut3 (
        .clock(clock), .resetn(resetn), .mode_in(m3_mode), .sel_in(m3_sel),
        .data_in(m3_data), .valid_in(m3_valid), .ready_out(m3_ready_out),
        .y_out(m3_y_out), .y_chan(m3_y_chan), .y_valid(m3_y_valid),
        .y_ready(m3_y_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // ---------------- reference model (4-channel instance) ----------------
    bit       m_valid;
    logic [7:0] m_data;
    int       m_chan;
    int       m_last;
    bit       mu_gv;
    int       mu_g;

    // Winner for the current inputs: fixed index, or scan the rotated
    // channel order starting just after the last round-robin winner.
    function automatic void model_grant(output bit gv, output int g);
        int order[$];
        gv = 1'b0;
        g  = 0;
        if (!mode_in) begin
            if (int'(sel_in) < CH && valid_in[sel_in]) begin
                gv = 1'b1;
                g  = int'(sel_in);
            end
        end else begin
            for (int d = 1; d <= CH; d++) order.push_back((m_last + d) % CH);
            foreach (order[j]) begin
                if (!gv && valid_in[order[j]]) begin
                    gv = 1'b1;
                    g  = order[j];
                end
            end
        end
    endfunction

    function automatic logic [3:0] model_ready();
        bit gv;
        int g;
        model_grant(gv, g);
        if (resetn && (!m_valid || y_ready) && gv) return 4'(1 << g);
        return 4'b0000;
    endfunction

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_chan  = 0;
            m_last  = CH - 1;
        end else begin
            model_grant(mu_gv, mu_g);
            if ((!m_valid || y_ready) && mu_gv) begin
                m_data  = data_in[mu_g*W +: W];
                m_chan  = mu_g;
                m_valid = 1'b1;
                if (mode_in) m_last = mu_g;
            end else if (m_valid && y_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit         mode;
        logic [1:0] sel;
        logic [3:0] valid;
        bit         yrdy;
        logic [3:0] exp_ready;  // before the edge
        bit         exp_yv;     // after the edge
        logic [1:0] exp_chan;   // after the edge
    } vec_t;

    vec_t vecs[13];

    localparam logic [31:0] STD_DATA = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

    function automatic logic [7:0] std_byte(input logic [1:0] c);
        return 8'hA0 + 8'h11 * {6'd0, c};
    endfunction

    initial begin
        logic [31:0] rnd;

        vecs[0]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[1]  = '{1'b0, 2'd2, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2};
        vecs[2]  = '{1'b0, 2'd2, 4'hF,    1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[3]  = '{1'b0, 2'd2, 4'hF,    1'b0, 4'b0000, 1'b1, 2'd2};
        vecs[4]  = '{1'b0, 2'd1, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[5]  = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0001, 1'b1, 2'd0};
        vecs[6]  = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[7]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3};
        vecs[8]  = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
        vecs[9]  = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1};
        vecs[10] = '{1'b0, 2'd0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[11] = '{1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 2'd0, 4'hF,    1'b1, 4'b0100, 1'b1, 2'd2};

        // ---- reset with random inputs ----
        resetn     = 1'b0;
        rnd        = $urandom;
        mode_in    = rnd[0];
        sel_in     = rnd[2:1];
        valid_in   = 4'hF;
        data_in    = $urandom;
        y_ready    = rnd[3];
        m3_mode    = 1'b0;
        m3_sel     = 2'd0;
        m3_valid   = 3'b111;
        m3_data    = 24'hC2B1A0;
        m3_y_ready = 1'b1;
        #2;
        check("reset ready_out", 32'(ready_out), 32'h0);
        check("reset y_valid",   32'(y_valid),   32'h0);
        check("reset y_out",     32'(y_out),     32'h0);
        check("reset y_chan",    32'(y_chan),    32'h0);
        check("reset ready3",    32'(m3_ready_out), 32'h0);
        tick();
        tick();
        resetn  = 1'b1;
        data_in = STD_DATA;

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) begin
            mode_in  = vecs[i].mode;
            sel_in   = vecs[i].sel;
            valid_in = vecs[i].valid;
            y_ready  = vecs[i].yrdy;
            #1;
            check($sformatf("vec%0d ready_out", i), 32'(ready_out), 32'(vecs[i].exp_ready));
            tick();
            check($sformatf("vec%0d y_valid", i), 32'(y_valid), 32'(vecs[i].exp_yv));
            check($sformatf("vec%0d y_chan", i),  32'(y_chan),  32'(vecs[i].exp_chan));
            check($sformatf("vec%0d y_out", i),   32'(y_out),   32'(std_byte(vecs[i].exp_chan)));
        end

        // ---- backpressure: hold for 5 cycles, then drain and refill together ----
        mode_in = 1'b0; sel_in = 2'd2; valid_in = 4'hF; y_ready = 1'b1;
        tick();
        check("bp load y_out", 32'(y_out), 32'hC2);
        y_ready = 1'b0;
        data_in[2*W +: W] = 8'h55;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp ready_out", 32'(ready_out), 32'h0);
            tick();
            check("bp y_valid", 32'(y_valid), 32'h1);
            check("bp y_out",   32'(y_out),   32'hC2);
        end
        y_ready = 1'b1;
        #1;
        check("bp release ready_out", 32'(ready_out), 32'b0100);
        tick();
        check("bp refill y_valid", 32'(y_valid), 32'h1);
        check("bp refill y_out",   32'(y_out),   32'h55);
        data_in = STD_DATA;

        // ---- round-robin rotation from a fresh reset ----
        resetn = 1'b0;
        #2;
        resetn = 1'b1;
        mode_in = 1'b1; valid_in = 4'hF; y_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr all y_chan",  32'(y_chan),  32'(i % 4));
            check("rr all y_valid", 32'(y_valid), 32'h1);
        end
        valid_in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr 1010 y_chan", 32'(y_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        // Pointer is now 3; fixed-mode beats must leave it there.
        mode_in = 1'b0; sel_in = 2'd0; valid_in = 4'hF;
        tick();
        check("fixed beat1 y_chan", 32'(y_chan), 32'd0);
        tick();
        check("fixed beat2 y_chan", 32'(y_chan), 32'd0);
        mode_in = 1'b1;
        tick();
        check("rr resume y_chan", 32'(y_chan), 32'd0);
        check("rr resume y_out",  32'(y_out),  32'hA0);

        // ---- asynchronous reset while FULL ----
        y_ready = 1'b0;
        #2;
        check("pre-async y_valid", 32'(y_valid), 32'h1);
        resetn = 1'b0;
        #1;
        check("async y_valid",   32'(y_valid),   32'h0);
        check("async y_out",     32'(y_out),     32'h0);
        check("async ready_out", 32'(ready_out), 32'h0);
        #2;
        resetn = 1'b1;
        tick();

        // ---- 3-channel instance: out-of-range select ----
        m3_mode = 1'b0; m3_sel = 2'd3; m3_valid = 3'b111; m3_y_ready = 1'b1;
        #1;
        check("ch3 sel3 ready_out", 32'(m3_ready_out), 32'h0);
        tick(); tick(); tick();
        check("ch3 sel3 y_valid", 32'(m3_y_valid), 32'h0);
        m3_sel = 2'd2;
        #1;
        check("ch3 sel2 ready_out", 32'(m3_ready_out), 32'b100);
        tick();
        check("ch3 sel2 y_valid", 32'(m3_y_valid), 32'h1);
        check("ch3 sel2 y_chan",  32'(m3_y_chan),  32'd2);
        check("ch3 sel2 y_out",   32'(m3_y_out),   32'hC2);

        // ---- randomized phase against the reference model ----
        for (int i = 0; i < 400; i++) begin
            rnd      = $urandom;
            mode_in  = rnd[0];
            sel_in   = rnd[2:1];
            valid_in = rnd[6:3];
            y_ready  = (rnd[9:7] != 3'd0);
            data_in  = $urandom;
            #1;
            check("rand ready_out", 32'(ready_out), 32'(model_ready()));
            tick();
            check("rand y_valid", 32'(y_valid), 32'(m_valid));
            check("rand y_chan",  32'(y_chan),  32'(m_chan));
            check("rand y_out",   32'(y_out),   32'(m_data));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
